inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction FIFO entries.
REQ-002 SHALL have parameter PROG_WORDS, default 16: program memory words, addressed by a 4-bit PC.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Run, input, 1: start request, honoured only in IDLE.
REQ-006 SHALL have port progWe, input, 1: program memory write enable.
REQ-007 SHALL have port progAddr, input, 4: program memory write address.
REQ-008 SHALL have port progData, input, 16: program memory write data.
REQ-009 SHALL have port disponivel, input, 1: reservation station free; an issue occurs when disponivel=1 and issueValid=1.
REQ-010 SHALL have port issueValid, output, 1: FIFO non-empty.
REQ-011 SHALL have port issueInst, output, 16: FIFO head instruction; 16'h0000 when empty.
REQ-012 SHALL have port count, output, 3: FIFO occupancy, 0..DEPTH.
REQ-013 SHALL have port halted, output, 1: fetch has stopped on HALT.

Function
REQ-014 SHALL decode instructions as imm[15:10], Rx[9:7], Ry[6:4], opcode[3:0]; opcodes ADD 0000, SUB 0001, LD 0010, SD 0011, MUL 0100, JMP 0101, HALT 1111.
REQ-015 SHALL implement FSM states IDLE, FETCH, HALTED; IDLE->FETCH on Run=1 with PC<=0; FETCH->HALTED on fetching HALT; HALTED->IDLE on Run=1 (PC not reset until next IDLE->FETCH).
REQ-016 SHALL, in FETCH, on each cycle in which count<DEPTH at cycle start, read progMem[PC] combinationally and act in that same cycle.
REQ-017 SHALL, for JMP, set PC<=imm[13:10] and not enqueue (one-cycle bubble, no flush of queued entries).
REQ-018 SHALL, for HALT, leave PC unchanged, not enqueue, and enter HALTED.
REQ-019 SHALL, for any other opcode, including undefined ones, enqueue the word at the tail and set PC<=PC+1, wrapping 15->0.
REQ-020 SHALL not fetch, and hold PC, when count=DEPTH at cycle start, even if an issue occurs that cycle.
REQ-021 SHALL pop the head when disponivel=1 and count>0, in any FSM state, with issueInst valid in the cycle of the handshake.
REQ-022 SHALL keep count unchanged on simultaneous enqueue and pop, +1 on enqueue only, -1 on pop only.
REQ-023 SHALL ignore disponivel when count=0: no underflow, issueValid=0, issueInst=0.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-025 SHALL write progMem[progAddr]<=progData on progWe=1 in any state; a same-cycle fetch from the same address returns the old word.
REQ-026 SHALL assert halted=1 exactly while in HALTED.
REQ-027 SHALL issue in program order; instructions are never reordered or dropped.

Reset
REQ-028 SHALL, on Reset=1 at posedge, set state=IDLE, PC=0, pointers=0, count=0, issueValid=0, issueInst=0, halted=0.
REQ-029 SHALL give Reset priority over Run, progWe, fetch and issue in the same cycle; queued entries are discarded.
REQ-030 SHALL not clear program memory on Reset.

Verification
REQ-031 SHALL cover: load 0x0000..0x0004 = ADD, SUB, LD, SD, HALT; Run; disponivel=1 -> issue order ADD,SUB,LD,SD; halted=1; count=0.
REQ-032 SHALL cover: 6 non-HALT words, disponivel=0 -> count saturates at 4; PC holds at 4; 5th word is not lost once disponivel=1.
REQ-033 SHALL cover: word 2 = JMP, imm[13:10]=7 (16'h1C05); word 7 = HALT -> entries from words 0,1 only; one fetch-bubble cycle; halted=1.
REQ-034 SHALL cover: queue full, disponivel=1 for one cycle -> count 4->3; fetch resumes the next cycle.
REQ-035 SHALL cover: Reset asserted with count=3 in FETCH -> next cycle count=0, issueValid=0, state IDLE; a later Run re-fetches from PC 0 with program memory intact.
REQ-036 SHALL cover: PC wrap with 16 non-HALT words and continuous issue -> after word 15 the next fetched word is word 0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch unit feeding an in-order issue FIFO
//
// Fetches 16-bit words from a small writable program memory and queues them
// for issue to a reservation station. JMP redirects the PC without queueing,
// HALT stops fetching. The FIFO drains in any state.
//
// Ports:
//   clock       in   1   single clock, all state changes on posedge
//   Reset       in   1   synchronous active-high reset
//   Run         in   1   start request (IDLE->FETCH) / re-arm (HALTED->IDLE)
//   progWe      in   1   program memory write enable
//   progAddr    in   4   program memory write address
//   progData    in  16   program memory write data
//   disponivel  in   1   reservation station free; pops the head when valid
//   issueValid  out  1   FIFO non-empty
//   issueInst   out 16   FIFO head word, zero when empty
//   count       out  3   FIFO occupancy 0..DEPTH
//   halted      out  1   high while fetch is stopped on HALT

module inst_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int PROG_WORDS = 16
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic        progWe,
  input  logic [3:0]  progAddr,
  input  logic [15:0] progData,
  input  logic        disponivel,
  output logic        issueValid,
  output logic [15:0] issueInst,
  output logic [2:0]  count,
  output logic        halted
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]        DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  logic [15:0] prog_mem [PROG_WORDS];
  logic [15:0] fifo_mem [DEPTH];

  state_e           state_q, state_d;
  logic [3:0]       pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]       count_q, count_d;

  logic [15:0] fetch_word;
  logic [3:0]  opcode;
  logic [3:0]  jmp_target;
  logic        enq;
  logic        pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Combinational read: the fetched word is acted on in the same cycle, and a
  // concurrent program write to the same address is only seen next cycle.
  assign fetch_word = prog_mem[pc_q];
  assign opcode     = fetch_word[3:0];
  assign jmp_target = fetch_word[13:10];

  assign pop = disponivel && (count_q != 3'd0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    enq     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Run) begin
          state_d = S_FETCH;
          pc_d    = 4'd0;
        end
      end

      S_FETCH: begin
        // Fullness is judged on the cycle-start count, so a pop in the same
        // cycle does not let a fetch slip in; the PC simply holds.
        if (count_q < DEPTH_C) begin
          case (opcode)
            OP_JMP:  pc_d    = jmp_target;
            OP_HALT: state_d = S_HALTED;
            default: begin
              enq  = 1'b1;
              pc_d = pc_q + 4'd1;
            end
          endcase
        end
      end

      S_HALTED: begin
        // PC is left alone here; it is cleared on the next IDLE->FETCH.
        if (Run) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({enq, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= 4'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage arrays carry no reset; program memory must survive Reset.
  always_ff @(posedge clock) begin
    if (enq && !Reset) fifo_mem[wr_ptr_q] <= fetch_word;
  end

  always_ff @(posedge clock) begin
    if (progWe && !Reset) prog_mem[progAddr] <= progData;
  end

  assign issueValid = (count_q != 3'd0);
  assign issueInst  = issueValid ? fifo_mem[rd_ptr_q] : 16'h0000;
  assign count      = count_q;
  assign halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue

module tb_inst_fetch_queue;

  logic        clock;
  logic        Reset;
  logic        Run;
  logic        progWe;
  logic [3:0]  progAddr;
  logic [15:0] progData;
  logic        disponivel;
  logic        issueValid;
  logic [15:0] issueInst;
  logic [2:0]  count;
  logic        halted;

  int checks;
  int failures;

  inst_fetch_queue #(.DEPTH(4), .PROG_WORDS(16)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .Run        (Run),
    .progWe     (progWe),
    .progAddr   (progAddr),
    .progData   (progData),
    .disponivel (disponivel),
    .issueValid (issueValid),
    .issueInst  (issueInst),
    .count      (count),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    progWe   = 1'b1;
    progAddr = a;
    progData = d;
    tick();
    progWe   = 1'b0;
  endtask

  task automatic chk_q(input string tag, input logic [2:0] c, input logic v,
                       input logic [15:0] head, input logic h);
    chk({tag, ".count"},  16'(count),      16'(c));
    chk({tag, ".valid"},  16'(issueValid), 16'(v));
    chk({tag, ".inst"},   issueInst,       head);
    chk({tag, ".halted"}, 16'(halted),     16'(h));
  endtask

  initial begin
    checks = 0; failures = 0;
    Reset = 1'b1; Run = 1'b0; progWe = 1'b0; progAddr = 4'd0;
    progData = 16'h0000; disponivel = 1'b0;
    #2;
    tick();
    chk_q("reset", 3'd0, 1'b0, 16'h0000, 1'b0);
    Reset = 1'b0;

    // Basic program ADD, SUB, LD, SD, HALT with continuous issue.
    load(4'd0, 16'h0120);
    load(4'd1, 16'h0091);
    load(4'd2, 16'h0412);
    load(4'd3, 16'h0833);
    load(4'd4, 16'h000F);
    chk_q("idle_no_fetch", 3'd0, 1'b0, 16'h0000, 1'b0);
    Run = 1'b1; tick(); Run = 1'b0;
    chk_q("run_accepted", 3'd0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk_q("first_fetch_add", 3'd1, 1'b1, 16'h0120, 1'b0);
    disponivel = 1'b1;
    tick(); chk_q("issue_sub", 3'd1, 1'b1, 16'h0091, 1'b0);
    tick(); chk_q("issue_ld",  3'd1, 1'b1, 16'h0412, 1'b0);
    tick(); chk_q("issue_sd",  3'd1, 1'b1, 16'h0833, 1'b0);
    tick(); chk_q("halt_drained", 3'd0, 1'b0, 16'h0000, 1'b1);
    tick(); chk_q("no_underflow", 3'd0, 1'b0, 16'h0000, 1'b1);
    disponivel = 1'b0;
    Run = 1'b1; tick(); Run = 1'b0;
    chk_q("halted_to_idle", 3'd0, 1'b0, 16'h0000, 1'b0);

    // Saturation with disponivel low, then release.
    load(4'd0, 16'hA000); load(4'd1, 16'hA010); load(4'd2, 16'hA020);
    load(4'd3, 16'hA030); load(4'd4, 16'hA040); load(4'd5, 16'hA050);
    load(4'd6, 16'h000F);
    Run = 1'b1; tick(); Run = 1'b0;
    tick(); tick(); tick();
    chk_q("fill3", 3'd3, 1'b1, 16'hA000, 1'b0);
    tick(); chk_q("fill4", 3'd4, 1'b1, 16'hA000, 1'b0);
    tick(); tick();
    chk_q("saturated", 3'd4, 1'b1, 16'hA000, 1'b0);
    disponivel = 1'b1;
    tick(); chk_q("full_pop_no_fetch", 3'd3, 1'b1, 16'hA010, 1'b0);
    disponivel = 1'b0;
    tick(); chk_q("fetch_resumes", 3'd4, 1'b1, 16'hA010, 1'b0);
    disponivel = 1'b1;
    tick(); chk_q("drain1", 3'd3, 1'b1, 16'hA020, 1'b0);
    tick(); chk_q("drain2", 3'd3, 1'b1, 16'hA030, 1'b0);
    tick(); chk_q("drain3_halt", 3'd2, 1'b1, 16'hA040, 1'b1);
    tick(); chk_q("drain4", 3'd1, 1'b1, 16'hA050, 1'b1);
    tick(); chk_q("drain5", 3'd0, 1'b0, 16'h0000, 1'b1);
    disponivel = 1'b0;
    Run = 1'b1; tick(); Run = 1'b0;

    // JMP to word 7 which holds HALT.
    load(4'd0, 16'hB000); load(4'd1, 16'hB010);
    load(4'd2, 16'h1C05); load(4'd7, 16'h000F);
    Run = 1'b1; tick(); Run = 1'b0;
    tick(); tick();
    chk_q("pre_jmp", 3'd2, 1'b1, 16'hB000, 1'b0);
    tick(); chk_q("jmp_bubble", 3'd2, 1'b1, 16'hB000, 1'b0);
    tick(); chk_q("jmp_target_halt", 3'd2, 1'b1, 16'hB000, 1'b1);
    disponivel = 1'b1;
    tick(); chk_q("jmp_issue1", 3'd1, 1'b1, 16'hB010, 1'b1);
    tick(); chk_q("jmp_issue2", 3'd0, 1'b0, 16'h0000, 1'b1);
    disponivel = 1'b0;
    Run = 1'b1; tick(); Run = 1'b0;

    // Reset while three entries are queued in FETCH.
    load(4'd2, 16'hB020);
    Run = 1'b1; tick(); Run = 1'b0;
    tick(); tick(); tick();
    chk_q("pre_reset", 3'd3, 1'b1, 16'hB000, 1'b0);
    Reset = 1'b1; Run = 1'b1; disponivel = 1'b1;
    tick();
    chk_q("mid_reset", 3'd0, 1'b0, 16'h0000, 1'b0);
    Reset = 1'b0; Run = 1'b0; disponivel = 1'b0;
    tick(); chk_q("post_reset_idle", 3'd0, 1'b0, 16'h0000, 1'b0);
    Run = 1'b1; tick(); Run = 1'b0;
    tick(); chk_q("refetch_pc0", 3'd1, 1'b1, 16'hB000, 1'b0);
    // Write to word 1 in the same cycle it is fetched: old word is queued.
    progWe = 1'b1; progAddr = 4'd1; progData = 16'hD000;
    tick(); progWe = 1'b0;
    chk_q("write_fetch_collide", 3'd2, 1'b1, 16'hB000, 1'b0);
    disponivel = 1'b1;
    tick(); chk_q("old_word_kept", 3'd2, 1'b1, 16'hB010, 1'b0);
    disponivel = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;

    // PC wrap across all 16 words with continuous issue.
    for (int i = 0; i < 16; i++) load(4'(i), 16'hC000 | 16'(i << 4));
    Run = 1'b1; tick(); Run = 1'b0;
    disponivel = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      tick();
      chk_q($sformatf("wrap%0d", j), 3'd1, 1'b1, 16'hC000 | 16'(((j - 1) % 16) << 4), 1'b0);
    end
    disponivel = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk_q("final_reset", 3'd0, 1'b0, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
